mips32_mem_arbiter: RTL
=======================

Name: mips32_mem_arbiter

Overview:
- Shares one single-ported, word-addressed memory between the instruction-fetch requester (I, read-only) and the data-access requester (D, read/write) of the mips32 pipeline.
- Handles one outstanding transaction at a time over a req/ack handshake.
- Data has fixed priority, with a starvation limit so fetch is never locked out.
- Supports cancellation of an in-flight fetch on a taken branch.

Parameters:
AW, 10, word-address width (1024-word memory)
DW, 32, data width
STARVE_LIMIT, 4, consecutive contested D grants before I is forced to win (1..15)

Ports:
clk1  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held until i_ack, or until i_flush
i_addr  in  AW  fetch word address; stable while i_req
i_flush  in  1  taken branch; cancels any pending or in-flight fetch
i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
i_rdata  out  DW  fetched instruction
d_req  in  1  data request; held until d_ack
d_we  in  1  1=store, 0=load; stable while d_req
d_addr  in  AW  data word address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse; load data valid or store done
d_rdata  out  DW  load data
mem_req  out  1  memory access strobe; held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion; sampled only in BUSY
busy  out  1  high in BUSY and RESP

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE. All outputs drive 0, including mem_req.
  - Starvation counter, owner and cancel flag clear.
  - A reset mid-transaction abandons that transaction; no ack is issued.
- All outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is valid (i_req counts only when i_flush=0), pick a winner.
  - Latch owner, addr, we and wdata (for I: we=0, wdata=0).
  - Next cycle: state BUSY, mem_req=1.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata stay constant.
  - On mem_ready=1: latch mem_rdata into the owner's rdata register (loads and fetches only); deassert mem_req next cycle; go to RESP.
  - There is no timeout; the block waits indefinitely.
- RESP:
  - The owner's ack is high for exactly this cycle, then the state returns to IDLE.
  - Because RESP lasts one cycle, a requester sees ack before IDLE resamples its req. This prevents a duplicate grant.
- Latency: req sampled at edge T; mem_req high from T+1. With mem_ready at T+1, ack is high in cycle T+2 and IDLE resumes at T+3. Each cycle mem_ready is delayed adds one cycle.
- Arbitration when only one requester is valid: that requester wins.
- Arbitration when both are valid:
  - D wins and the starvation counter increments.
  - If the counter equals STARVE_LIMIT, I wins and the counter clears.
  - The counter also clears whenever I is granted or i_req is low in IDLE.
- Fetch cancellation:
  - If i_flush=1 while owner=I in BUSY or RESP, set the cancel flag.
  - A cancelled transaction still completes at the memory but suppresses i_ack. i_rdata is still updated.
  - The flag clears on return to IDLE.
  - i_flush with owner=D has no effect on the D transaction.
- d_rdata is unchanged on stores. i_rdata and d_rdata hold their values between acks.
- mem_ready is ignored in IDLE and RESP.
- i_ack and d_ack are never high in the same cycle.

Decomposition:
- Shared package mips32_pkg holds:
  - state enum (IDLE/BUSY/RESP)
  - owner encoding (OWN_I=0, OWN_D=1)
  - AW/DW defaults
- One natural sub-module, mips32_arb_prio: combinational winner select plus the registered starvation counter. It takes i_valid, d_valid and an idle strobe, and outputs grant_i, grant_d.

Test Plan:
- Lone fetch: i_req, addr 0x010, mem_ready on the first BUSY cycle, mem_rdata=0x2041000A -> mem_req high 1 cycle, i_ack in cycle T+2 with i_rdata=0x2041000A, busy low by T+3.
- Store then load: d_we=1, addr 0x3FF, data 0xDEADBEEF, then a load from 0x3FF with the memory model returning stored data -> mem_we=1 on the first access, d_ack twice, d_rdata=0xDEADBEEF, d_rdata unchanged after the store ack.
- Contention starvation (STARVE_LIMIT=4): i_req and d_req both held continuously, D re-requesting after each ack -> grant order D,D,D,D,I,D,D,D,D,I; never two acks in one cycle.
- Flush in flight: fetch granted, mem_ready delayed 3 cycles, i_flush pulsed in BUSY -> memory access completes, no i_ack, next IDLE serves a pending d_req.
- Reset mid-op: assert reset in BUSY -> mem_req, busy and acks go 0 immediately (before the next clk1 edge), no ack after release, a fresh request completes normally.
- Stalled memory: mem_ready held low 20 cycles -> mem_addr, mem_we and mem_wdata constant throughout, no ack until mem_ready, then exactly one ack.

Source files
------------

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared types and defaults for the mips32 memory arbiter
package mips32_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mips32_arb_prio.sv
// rtl/mips32_arb_prio.sv - fixed data priority with a starvation limit for fetch
module mips32_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk1,
    input  logic reset,
    input  logic i_valid,
    input  logic d_valid,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       contested;
    logic       force_i;

    assign contested = i_valid & d_valid;
    assign force_i   = contested & (starve_cnt == LIMIT);
    assign grant_i   = idle & i_valid & (~d_valid | force_i);
    assign grant_d   = idle & d_valid & ~force_i;

    // Only a contested data win extends the streak; anything else seen in idle restarts it.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (idle) begin
            starve_cnt <= (contested & ~force_i) ? starve_cnt + 4'd1 : '0;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - single-port memory shared by fetch and data requesters
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    state_t state;
    state_t state_next;
    owner_t owner;
    logic   cancel;
    logic   in_idle;
    logic   i_valid;
    logic   grant_i;
    logic   grant_d;
    logic   flush_hit;

    assign in_idle   = (state == ST_IDLE);
    assign i_valid   = i_req & ~i_flush;
    assign flush_hit = i_flush & (owner == OWN_I);

    mips32_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk1    (clk1),
        .reset   (reset),
        .i_valid (i_valid),
        .d_valid (d_req),
        .idle    (in_idle),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_i | grant_d) state_next = ST_BUSY;
            ST_BUSY: if (mem_ready)         state_next = ST_RESP;
            ST_RESP:                        state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // Acks are computed at the completing edge so they appear for exactly the RESP cycle.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            owner     <= OWN_I;
            cancel    <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cancel <= 1'b0;
                    if (grant_i | grant_d) begin
                        owner     <= grant_d ? OWN_D : OWN_I;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_we    <= grant_d & d_we;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (flush_hit) cancel <= 1'b1;
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= ~(cancel | i_flush);
                        end else begin
                            if (!mem_we) d_rdata <= mem_rdata;
                            d_ack <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (flush_hit) cancel <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
